// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared defaults and phase FSM encoding for the three-phase dead-time PWM
// generator. Optional feature macro: PWM_MIN_PULSE_EN (see pwm_deadtime_gen.sv).
package pwm_deadtime_gen_pkg;

  localparam int CNT_WIDTH_DEF       = 12;
  localparam int PWM_PERIOD_HALF_DEF = 2500;
  localparam int DEADTIME_CYC_DEF    = 50;
  localparam int MIN_PULSE_CYC_DEF   = 25;

  typedef enum logic [1:0] {
    PH_DEAD    = 2'd0,
    PH_HIGH_ON = 2'd1,
    PH_LOW_ON  = 2'd2
  } phase_state_t;

endpackage

// File: rtl/pwm_deadtime_gen_phase_unit.sv
// One leg of the bridge: registers the raw compare result and runs the
// DEAD / HIGH_ON / LOW_ON state machine that enforces the dead time between
// the high-side and low-side gate commands.
module deadtime_phase_unit
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DEADTIME_CYC = DEADTIME_CYC_DEF
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic pwm_en,
  input  logic raw_in,
  output logic high_out,
  output logic low_out
);

  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEADTIME_CYC - 1);

  logic          raw_p1;
  phase_state_t  state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;

  // Stage p1: raw compare registered once; it carries no reset since it is
  // refreshed every cycle and ignored while the FSM sits in DEAD.
  always_ff @(posedge sys_clk) begin
    raw_p1 <= raw_in;
  end

  // State register and dead-time counter.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= PH_DEAD;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Next-state and gate decode; dcnt only advances while DEAD so a raw
  // reversal inside the dead window does not restart it.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    high_out  = 1'b0;
    low_out   = 1'b0;
    case (state)
      PH_HIGH_ON: high_out = 1'b1;
      PH_LOW_ON:  low_out  = 1'b1;
      default:    ;
    endcase
    if (!pwm_en) begin
      state_nxt = PH_DEAD;
      dcnt_nxt  = '0;
    end else begin
      case (state)
        PH_DEAD: begin
          if (dcnt == DCNT_LAST) begin
            state_nxt = raw_p1 ? PH_HIGH_ON : PH_LOW_ON;
            dcnt_nxt  = '0;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
        PH_HIGH_ON: begin
          if (!raw_p1) begin
            state_nxt = PH_DEAD;
            dcnt_nxt  = '0;
          end
        end
        PH_LOW_ON: begin
          if (raw_p1) begin
            state_nxt = PH_DEAD;
            dcnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = PH_DEAD;
          dcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Three-phase centre-aligned PWM generator with complementary dead time.
// Holds the up/down carrier, zero/peak strobes, double-buffered duty words
// (pending -> active on the carrier zero) and the per-phase compare.
// Define PWM_MIN_PULSE_EN to snap duty words that would yield pulses shorter
// than MIN_PULSE_CYC to fully off / fully on.
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int PWM_PERIOD_HALF = PWM_PERIOD_HALF_DEF,
  parameter int DEADTIME_CYC    = DEADTIME_CYC_DEF,
  parameter int MIN_PULSE_CYC   = MIN_PULSE_CYC_DEF
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 pwm_en,
  input  logic                 duty_valid,
  input  logic [CNT_WIDTH-1:0] duty_a,
  input  logic [CNT_WIDTH-1:0] duty_b,
  input  logic [CNT_WIDTH-1:0] duty_c,
  output logic                 gate_a_high_side_out,
  output logic                 gate_a_low_side_out,
  output logic                 gate_b_high_side_out,
  output logic                 gate_b_low_side_out,
  output logic                 gate_c_high_side_out,
  output logic                 gate_c_low_side_out,
  output logic                 carrier_zero_out,
  output logic                 carrier_peak_out
);

  localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(PWM_PERIOD_HALF);
  localparam logic [CNT_WIDTH-1:0] MINP = CNT_WIDTH'(MIN_PULSE_CYC);

`ifdef PWM_MIN_PULSE_EN
  localparam bit MIN_PULSE_ON = 1'b1;
`else
  localparam bit MIN_PULSE_ON = 1'b0;
`endif

  // Saturate an incoming duty word to the carrier peak.
  function automatic logic [CNT_WIDTH-1:0] sat_duty(input logic [CNT_WIDTH-1:0] d);
    return (d > HALF) ? HALF : d;
  endfunction

  // Snap near-empty / near-full duty to 0 / HALF when pulse suppression is on.
  function automatic logic [CNT_WIDTH-1:0] shape_duty(input logic [CNT_WIDTH-1:0] d);
    if (MIN_PULSE_ON && (d < MINP))
      return '0;
    if (MIN_PULSE_ON && (d > (HALF - MINP)))
      return HALF;
    return d;
  endfunction

  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 dir_up, dir_up_nxt;
  logic                 zero_q, peak_q;
  logic                 at_zero;

  logic [CNT_WIDTH-1:0] duty_in  [3];
  logic [CNT_WIDTH-1:0] duty_pnd [3];
  logic [CNT_WIDTH-1:0] duty_act [3];
  logic [CNT_WIDTH-1:0] duty_eff [3];
  logic                 pnd_flag;
  logic [2:0]           raw_cmp;
  logic [2:0]           gate_high;
  logic [2:0]           gate_low;

  assign duty_in[0] = duty_a;
  assign duty_in[1] = duty_b;
  assign duty_in[2] = duty_c;
  assign at_zero    = (cnt == '0);

  // Carrier next value: up 0..HALF, down HALF-1..1, then back to 0.
  always_comb begin
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    if (dir_up) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == HALF - 1'b1)
        dir_up_nxt = 1'b0;
    end else begin
      cnt_nxt = cnt - 1'b1;
      if (cnt == CNT_WIDTH'(1))
        dir_up_nxt = 1'b1;
    end
  end

  // Carrier register; strobes are registered from the next count so they
  // line up exactly with the cnt==0 / cnt==HALF cycles.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt    <= '0;
      dir_up <= 1'b1;
      zero_q <= 1'b0;
      peak_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      dir_up <= dir_up_nxt;
      zero_q <= (cnt_nxt == '0);
      peak_q <= (cnt_nxt == HALF);
    end
  end

  // Duty double buffer: capture to pending, promote on the carrier zero;
  // a strobe landing on the zero cycle bypasses the pending stage.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pnd_flag <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        duty_pnd[i] <= '0;
        duty_act[i] <= '0;
      end
    end else if (duty_valid && at_zero) begin
      pnd_flag <= 1'b0;
      for (int i = 0; i < 3; i++)
        duty_act[i] <= sat_duty(duty_in[i]);
    end else if (duty_valid) begin
      pnd_flag <= 1'b1;
      for (int i = 0; i < 3; i++)
        duty_pnd[i] <= sat_duty(duty_in[i]);
    end else if (at_zero && pnd_flag) begin
      pnd_flag <= 1'b0;
      for (int i = 0; i < 3; i++)
        duty_act[i] <= duty_pnd[i];
    end
  end

  // Stage p0: compare against the carrier, then one dead-time unit per leg.
  for (genvar p = 0; p < 3; p++) begin : g_phase
    assign duty_eff[p] = shape_duty(duty_act[p]);
    assign raw_cmp[p]  = (duty_eff[p] >= HALF) || (cnt < duty_eff[p]);

    deadtime_phase_unit #(
      .DEADTIME_CYC (DEADTIME_CYC)
    ) u_phase (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .pwm_en   (pwm_en),
      .raw_in   (raw_cmp[p]),
      .high_out (gate_high[p]),
      .low_out  (gate_low[p])
    );
  end

  assign gate_a_high_side_out = gate_high[0];
  assign gate_a_low_side_out  = gate_low[0];
  assign gate_b_high_side_out = gate_high[1];
  assign gate_b_low_side_out  = gate_low[1];
  assign gate_c_high_side_out = gate_high[2];
  assign gate_c_low_side_out  = gate_low[2];
  assign carrier_zero_out     = zero_q;
  assign carrier_peak_out     = peak_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Testbench for pwm_deadtime_gen: table of steady-state duty vectors plus
// directed sequences for duty buffering, pwm_en toggling and mid-run reset.
module tb_pwm_deadtime_gen;

  localparam int CW = 12;
  localparam int H  = 100;
  localparam int DT = 5;
  localparam int MP = 10;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          pwm_en = 1'b0;
  logic          duty_valid = 1'b0;
  logic [CW-1:0] duty_a = '0, duty_b = '0, duty_c = '0;
  logic          gah, gal, gbh, gbl, gch, gcl, czero, cpeak;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  pwm_deadtime_gen #(
    .CNT_WIDTH       (CW),
    .PWM_PERIOD_HALF (H),
    .DEADTIME_CYC    (DT),
    .MIN_PULSE_CYC   (MP)
  ) dut (
    .sys_clk              (sys_clk),
    .reset                (reset),
    .pwm_en               (pwm_en),
    .duty_valid           (duty_valid),
    .duty_a               (duty_a),
    .duty_b               (duty_b),
    .duty_c               (duty_c),
    .gate_a_high_side_out (gah),
    .gate_a_low_side_out  (gal),
    .gate_b_high_side_out (gbh),
    .gate_b_low_side_out  (gbl),
    .gate_c_high_side_out (gch),
    .gate_c_low_side_out  (gcl),
    .carrier_zero_out     (czero),
    .carrier_peak_out     (cpeak)
  );

  // Reference carrier position, advanced on the same edges as the design.
  int mcnt = 0;
  bit mup = 1'b1;
  bit rst_seen = 1'b1;
  bit mon_en = 1'b0;

  always @(posedge sys_clk) begin
    if (reset) begin
      mcnt     <= 0;
      mup      <= 1'b1;
      rst_seen <= 1'b1;
    end else begin
      rst_seen <= 1'b0;
      if (mup) begin
        if (mcnt == H - 1) mup <= 1'b0;
        mcnt <= mcnt + 1;
      end else begin
        if (mcnt == 1) mup <= 1'b1;
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Every cycle: strobes against the reference carrier, no leg overlap.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("carrier_zero", czero, ((mcnt == 0) && !rst_seen) ? 1 : 0);
      chk("carrier_peak", cpeak, (mcnt == H) ? 1 : 0);
      chk("overlap_a", gah & gal, 0);
      chk("overlap_b", gbh & gbl, 0);
      chk("overlap_c", gch & gcl, 0);
    end
  end

  task automatic pulse_duty(input int a, input int b, input int c);
    duty_a     = CW'(a);
    duty_b     = CW'(b);
    duty_c     = CW'(c);
    duty_valid = 1'b1;
    @(negedge sys_clk);
    duty_valid = 1'b0;
  endtask

  task automatic wait_zero();
    int k = 0;
    @(negedge sys_clk);
    while (!czero && k < 4 * H) begin
      @(negedge sys_clk);
      k++;
    end
    if (!czero) timeout("wait_zero");
  endtask

  task automatic wait_cnt(input int c, input bit up);
    int k = 0;
    @(negedge sys_clk);
    while (!(mcnt == c && mup == up) && k < 4 * H) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= 4 * H) timeout("wait_cnt");
  endtask

  task automatic low_run(output int len);
    int k = 0;
    len = 0;
    while (gal && k < 4 * H) begin @(negedge sys_clk); k++; end
    while (!gal && k < 4 * H) begin @(negedge sys_clk); k++; end
    while (gal && k < 4 * H) begin len++; @(negedge sys_clk); k++; end
    if (k >= 4 * H) timeout("low_run");
  endtask

  int meas_h[3];
  int meas_l[3];

  task automatic measure_period();
    for (int p = 0; p < 3; p++) begin
      meas_h[p] = 0;
      meas_l[p] = 0;
    end
    for (int k = 0; k < 2 * H; k++) begin
      meas_h[0] += int'(gah); meas_l[0] += int'(gal);
      meas_h[1] += int'(gbh); meas_l[1] += int'(gbl);
      meas_h[2] += int'(gch); meas_l[2] += int'(gcl);
      @(negedge sys_clk);
    end
  endtask

  typedef struct {
    int da, db, dc;
    int ha, la, hb, lb, hc, lc;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int len;
    logic [5:0] g;

    // Per-period on-time counts (high, low) for duty d, DT=5, H=100:
    // high = 2d-1-5, low = 201-2d-5, with runs shorter than DT swallowed.
    vecs[0] = '{50, 0, 100, 94, 96, 0, 200, 200, 0};
`ifdef PWM_MIN_PULSE_EN
    vecs[1] = '{3, 95, 25, 0, 200, 200, 0, 44, 146};
    vecs[2] = '{4, 99, 75, 0, 200, 200, 0, 144, 46};
    vecs[3] = '{1, 200, 10, 0, 200, 200, 0, 14, 176};
`else
    vecs[1] = '{3, 95, 25, 0, 195, 184, 6, 44, 146};
    vecs[2] = '{4, 99, 75, 2, 188, 195, 0, 144, 46};
    vecs[3] = '{1, 200, 10, 0, 195, 200, 0, 14, 176};
`endif

    // Reset held three cycles, switching disabled.
    repeat (3) @(negedge sys_clk);
    chk("reset_gates", {gah, gal, gbh, gbl, gch, gcl}, 0);
    chk("reset_zero", czero, 0);
    chk("reset_peak", cpeak, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Carrier runs with pwm_en=0, all gates stay off.
    for (int i = 0; i < 450; i++) begin
      @(negedge sys_clk);
      chk("disabled_gates", {gah, gal, gbh, gbl, gch, gcl}, 0);
    end
    wait_zero();
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!cpeak && k < 4 * H);
    chk("zero_to_peak", k, H);
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!czero && k < 4 * H);
    chk("peak_to_zero", k, H);

    // Steady-state vector table.
    pwm_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_duty(vecs[i].da, vecs[i].db, vecs[i].dc);
      wait_zero();
      wait_zero();
      measure_period();
      chk($sformatf("v%0d_high_a", i), meas_h[0], vecs[i].ha);
      chk($sformatf("v%0d_low_a", i),  meas_l[0], vecs[i].la);
      chk($sformatf("v%0d_high_b", i), meas_h[1], vecs[i].hb);
      chk($sformatf("v%0d_low_b", i),  meas_l[1], vecs[i].lb);
      chk($sformatf("v%0d_high_c", i), meas_h[2], vecs[i].hc);
      chk($sformatf("v%0d_low_c", i),  meas_l[2], vecs[i].lc);
    end

    // Duty buffering: 30 at cnt=40 up, 70 at cnt=60 down; 50 holds this period.
    pulse_duty(50, 0, 100);
    wait_zero();
    wait_zero();
    wait_cnt(40, 1'b1);
    pulse_duty(30, 0, 100);
    len = 0;
    k = 0;
    g[0] = 1'b0;
    while (k < 4 * H) begin
      if (mcnt == 60 && !mup) begin
        duty_a = CW'(70);
        duty_valid = 1'b1;
      end else begin
        duty_valid = 1'b0;
      end
      if (gal) begin
        g[0] = 1'b1;
        len++;
      end else if (g[0]) begin
        break;
      end
      @(negedge sys_clk);
      k++;
    end
    duty_valid = 1'b0;
    if (k >= 4 * H) timeout("buffer_run");
    chk("low_a_old_duty", len, 96);
    wait_zero();
    low_run(len);
    chk("low_a_new_duty", len, 56);
    low_run(len);
    chk("low_a_new_duty_2", len, 56);

    // Strobe on the zero cycle goes straight to active.
    wait_cnt(0, 1'b1);
    pulse_duty(40, 0, 100);
    low_run(len);
    chk("low_a_zero_bypass", len, 116);

    // pwm_en dropped while high_a is on.
    k = 0;
    while (!gah && k < 4 * H) begin @(negedge sys_clk); k++; end
    if (!gah) timeout("wait_high_a");
    pwm_en = 1'b0;
    @(negedge sys_clk);
    chk("en_drop_gates", {gah, gal, gbh, gbl, gch, gcl}, 0);
    repeat (20) @(negedge sys_clk);
    chk("en_low_gates", {gah, gal, gbh, gbl, gch, gcl}, 0);

    // pwm_en re-raised at cnt=75 up: five dead cycles, then a low, b low, c high.
    wait_cnt(75, 1'b1);
    pwm_en = 1'b1;
    chk("en_rise_now", {gah, gal, gbh, gbl, gch, gcl}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      g = {gah, gal, gbh, gbl, gch, gcl};
      if (i < 4) chk($sformatf("en_rise_dead_%0d", i), g, 0);
      else       chk("en_rise_side", g, 6'b010110);
    end

    // Reset pulsed mid-period with gates conducting.
    wait_cnt(30, 1'b1);
    chk("pre_reset_active", {gah, gal, gbh, gbl, gch, gcl}, 6'b100110);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("mid_reset_gates", {gah, gal, gbh, gbl, gch, gcl}, 0);
    reset = 1'b0;
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!cpeak && k < 4 * H);
    chk("reset_to_peak", k, H);
    k = 0;
    do begin @(negedge sys_clk); k++; end while (!czero && k < 4 * H);
    chk("reset_peak_to_zero", k, H);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
